avalon_pio_master: RTL and testbench

Avalon-MM initiator that turns single-beat command requests from debug or control logic into read and write transfers on the PIO slave bus. It targets the SoC's register-mapped PIO ports, such as the debug PC/instruction taps. Each command is carried out as one bus transfer, honouring `avm_waitrequest` and a fixed slave read latency. Each command returns exactly one response: read data, a write acknowledge, or a timeout error.

---
 rtl/avalon_pio_master.sv | 200 ++++++++++++++++++++
 tb/tb_avalon_pio_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_pio_master.sv
// avalon_pio_master
//
// Avalon-MM initiator that turns single-beat read/write commands into one
// transfer each on a register-mapped PIO slave bus. One transfer is in flight
// at a time; every accepted command yields exactly one response (read data,
// write acknowledge, or a timeout error).
//
// Ports
//   clk, reset          : single rising-edge clock, asynchronous active-high reset
//   cmd_valid/ready     : command handshake (ready only while idle)
//   cmd_write/addr/wdata: command fields (1 = write)
//   rsp_valid/ready     : response handshake; response held until accepted
//   rsp_rdata/error     : read data (0 for writes/errors), timeout flag
//   avm_*               : Avalon-MM initiator signals, all registered
//
// Parameters
//   ADDR_W       : word address width
//   READ_LATENCY : fixed slave read latency in cycles (1..7)
//   TIMEOUT      : consecutive waitrequest cycles before abort, 0 = never

module avalon_pio_master #(
  parameter int ADDR_W       = 2,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0]  LAT_INIT  = 3'(READ_LATENCY - 1);
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  // Saturating 16-bit increment for the wait-state counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end
    return v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [15:0]       wait_cnt_q, wait_cnt_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [ADDR_W-1:0] avm_address_q, avm_address_d;
  logic              avm_chipselect_q, avm_chipselect_d;
  logic              avm_write_n_q, avm_write_n_d;
  logic              avm_read_n_q, avm_read_n_d;
  logic [31:0]       avm_writedata_q, avm_writedata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_error_q, rsp_error_d;
  logic [15:0]       wait_inc;

  // cmd_ready is forced low while reset is held even though state is IDLE.
  assign cmd_ready      = (state_q == IDLE) && !reset;

  assign avm_address    = avm_address_q;
  assign avm_chipselect = avm_chipselect_q;
  assign avm_write_n    = avm_write_n_q;
  assign avm_read_n     = avm_read_n_q;
  assign avm_writedata  = avm_writedata_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_error      = rsp_error_q;

  assign wait_inc       = sat_inc16(wait_cnt_q);

  always_comb begin
    state_d          = state_q;
    wait_cnt_d       = wait_cnt_q;
    lat_cnt_d        = lat_cnt_q;
    avm_address_d    = avm_address_q;
    avm_chipselect_d = avm_chipselect_q;
    avm_write_n_d    = avm_write_n_q;
    avm_read_n_d     = avm_read_n_q;
    avm_writedata_d  = avm_writedata_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_error_d      = rsp_error_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          // Strobes are launched here so they are registered on entry to REQ.
          avm_address_d    = cmd_addr;
          avm_writedata_d  = cmd_wdata;
          avm_chipselect_d = 1'b1;
          avm_write_n_d    = !cmd_write;
          avm_read_n_d     = cmd_write;
          wait_cnt_d       = 16'd0;
          state_d          = REQ;
        end
      end

      REQ: begin
        if (!avm_waitrequest) begin
          avm_chipselect_d = 1'b0;
          avm_write_n_d    = 1'b1;
          avm_read_n_d     = 1'b1;
          // The active write strobe identifies the transfer direction.
          if (!avm_write_n_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'd0;
            rsp_error_d = 1'b0;
            state_d     = RESP;
          end else begin
            lat_cnt_d = LAT_INIT;
            state_d   = RDWAIT;
          end
        end else begin
          wait_cnt_d = wait_inc;
          // Abort on the edge that completes the TIMEOUT-th stalled cycle.
          if ((TIMEOUT != 0) && (wait_inc >= TIMEOUT_L)) begin
            avm_chipselect_d = 1'b0;
            avm_write_n_d    = 1'b1;
            avm_read_n_d     = 1'b1;
            rsp_valid_d      = 1'b1;
            rsp_rdata_d      = 32'd0;
            rsp_error_d      = 1'b1;
            state_d          = RESP;
          end
        end
      end

      RDWAIT: begin
        if (lat_cnt_q == 3'd0) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = avm_readdata;
          rsp_error_d = 1'b0;
          state_d     = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      wait_cnt_q       <= 16'd0;
      lat_cnt_q        <= 3'd0;
      avm_address_q    <= '0;
      avm_chipselect_q <= 1'b0;
      avm_write_n_q    <= 1'b1;
      avm_read_n_q     <= 1'b1;
      avm_writedata_q  <= 32'd0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= 32'd0;
      rsp_error_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      lat_cnt_q        <= lat_cnt_d;
      avm_address_q    <= avm_address_d;
      avm_chipselect_q <= avm_chipselect_d;
      avm_write_n_q    <= avm_write_n_d;
      avm_read_n_q     <= avm_read_n_d;
      avm_writedata_q  <= avm_writedata_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_error_q      <= rsp_error_d;
    end
  end

endmodule

// File: tb/tb_avalon_pio_master.sv
// Testbench for avalon_pio_master: directed cases followed by randomized
// commands, with a PIO-style slave model, a reference memory and a
// scoreboard checked by a negedge monitor.

module tb_avalon_pio_master;

  localparam int ADDR_W = 2;
  localparam int RL     = 1;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = 32'd0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_chipselect;
  logic              avm_write_n;
  logic              avm_read_n;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;

  avalon_pio_master #(
    .ADDR_W(ADDR_W), .READ_LATENCY(RL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return 32'h12345678 + 32'(i) * 32'h01010101;
  endfunction

  // PIO-style slave: registered readdata, stalls the first wait_cfg cycles
  // of every chipselect burst.
  int          wait_cfg = 0;
  int          cs_cycles;
  logic [31:0] smem [4];
  logic [31:0] rd_q;

  assign avm_waitrequest = avm_chipselect && (cs_cycles < wait_cfg);
  assign avm_readdata    = rd_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) smem[i] <= init_val(i);
      cs_cycles <= 0;
      rd_q      <= 32'd0;
    end else begin
      cs_cycles <= avm_chipselect ? cs_cycles + 1 : 0;
      if (avm_chipselect && !avm_waitrequest) begin
        if (!avm_write_n) smem[avm_address] <= avm_writedata;
        if (!avm_read_n)  rd_q <= smem[avm_address];
      end
    end
  end

  // rsp_ready driver: forced low until bp_until, otherwise random or high.
  int bp_until = 0;
  bit rnd_rdy  = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = (cyc < bp_until) ? 1'b0 :
                  (rnd_rdy ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              err;
    int                exp_cyc;
    int                cs;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [4];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void check(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Monitor: bus protocol, response contents/timing, stability, reset values.
  bit          in_rsp = 1'b0;
  bit          exp_ready_next = 1'b0;
  bit          prev_reset = 1'b1;
  int          cs_count = 0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      check("reset_ctl",
            {56'd0, avm_chipselect, avm_write_n, avm_read_n, rsp_valid,
             rsp_error, cmd_ready, avm_address},
            {56'd0, 6'b011000, 2'b00});
      check("reset_data", {avm_writedata, rsp_rdata}, 64'd0);
      in_rsp         = 1'b0;
      exp_ready_next = 1'b0;
      cs_count       = 0;
    end else begin
      if (prev_reset) check("post_reset_idle", {62'd0, cmd_ready, rsp_valid}, 64'd2);
      if (exp_ready_next) begin
        check("ready_after_rsp", {63'd0, cmd_ready}, 64'd1);
        exp_ready_next = 1'b0;
      end
      if (avm_chipselect) begin
        cs_count++;
        if (sbq.size() > 0)
          check("bus_req", {avm_write_n, avm_read_n, avm_address, avm_writedata},
                {!sbq[0].wr, sbq[0].wr, sbq[0].addr, sbq[0].wdata});
      end else begin
        check("bus_idle", {62'd0, avm_write_n, avm_read_n}, 64'd3);
      end
      if (rsp_valid) begin
        check("busy_not_ready", {63'd0, cmd_ready}, 64'd0);
        if (!in_rsp) begin
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, e.rdata});
            check("rsp_error", {63'd0, rsp_error}, {63'd0, e.err});
            check("rsp_latency", 64'(cyc), 64'(e.exp_cyc));
            check("strobe_cycles", 64'(cs_count), 64'(e.cs));
          end
          cs_count   = 0;
          hold_rdata = rsp_rdata;
          hold_err   = rsp_error;
        end else begin
          check("rsp_stable", {31'd0, rsp_error, rsp_rdata}, {31'd0, hold_err, hold_rdata});
        end
        if (rsp_ready) begin
          in_rsp         = 1'b0;
          exp_ready_next = 1'b1;
        end else begin
          in_rsp = 1'b1;
        end
      end else if (sbq.size() > 0 && cyc > sbq[0].exp_cyc) begin
        n_chk++;
        $display("FAIL missing_rsp: got no response expected one by cycle %0d", sbq[0].exp_cyc);
        void'(sbq.pop_front());
        cs_count = 0;
      end
    end
    prev_reset = reset;
  end

  // Issue one command; the reference model derives the expected response.
  task automatic send(input bit wr, input logic [ADDR_W-1:0] a,
                      input logic [31:0] d, input int w);
    int   k;
    bit   tmo;
    int   lat;
    exp_t e;
    @(negedge clk);
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready) begin
      k++;
      if (k > 300) begin
        $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 300 cycles");
        $fatal(1, "command never accepted");
      end
      @(negedge clk);
    end
    wait_cfg  = w;
    tmo       = (w >= TO);
    lat       = tmo ? TO + 1 : (wr ? w + 2 : w + 2 + RL);
    e.wr      = wr;
    e.addr    = a;
    e.wdata   = d;
    e.rdata   = (tmo || wr) ? 32'd0 : ref_mem[a];
    e.err     = tmo;
    e.exp_cyc = cyc + lat;
    e.cs      = tmo ? TO : w + 1;
    if (wr && !tmo) ref_mem[a] = d;
    sbq.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  initial begin
    int k;
    int r;
    int w;
    for (int i = 0; i < 4; i++) ref_mem[i] = init_val(i);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset in the middle of a write's REQ cycle: command dropped, no response.
    @(negedge clk);
    cmd_write = 1'b1;
    cmd_addr  = 2'd1;
    cmd_wdata = 32'hAAAA5555;
    cmd_valid = 1'b1;
    wait_cfg  = 0;
    k = 0;
    while (!cmd_ready && k < 20) begin
      k++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed cases
    send(1'b0, 2'd0, 32'd0, 0);           // PIO read, 0x12345678
    send(1'b1, 2'd0, 32'hDEADBEEF, 0);    // write, no wait
    send(1'b0, 2'd0, 32'd0, 4);           // read with 4 wait states
    send(1'b0, 2'd2, 32'd0, 20);          // read timeout
    send(1'b1, 2'd3, 32'hCAFEF00D, 9);    // write timeout, memory untouched
    send(1'b0, 2'd3, 32'd0, 0);
    bp_until = cyc + 12;                  // rsp_ready low ~10 cycles
    send(1'b1, 2'd1, 32'h00000055, 0);
    send(1'b0, 2'd1, 32'd0, 0);           // pending during backpressure

    // Randomized commands
    rnd_rdy = 1'b1;
    repeat (60) begin
      r = $urandom_range(9);
      if (r < 6)      w = r % 3;
      else if (r < 8) w = r - 2;
      else            w = TO + (r - 8) * 3;
      send(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom, w);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end

    k = 0;
    while (sbq.size() != 0 && k < 2000) begin
      k++;
      @(negedge clk);
    end
    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d outstanding responses expected 0", sbq.size());
      $fatal(1, "responses never arrived");
    end
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
